fp_accum8: RTL and testbench

Sequencer that sums groups of N single-precision products into one coefficient, using the shared AXI-stream floating-point adder (Add_Floating) as its arithmetic unit. It sits directly upstream of the adder, driving its A/B operand channels, and directly downstream of it, consuming its result channel. Each finished sum goes to the quantisation stage, tagged with a 6-bit coefficient index for the 8x8 DCT block.

---
 rtl/fp_accum8_if.sv | 50 +++++
 rtl/fp_accum8.sv | 140 ++++++++++++++
 tb/tb_fp_accum8.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_accum8_if.sv
// Stream bundle around fp_accum8: product input, adder operand/result channels
// and the finished-coefficient output.
interface fp_accum8_if;
    logic        s_axis_prod_tvalid;
    logic        s_axis_prod_tready;
    logic [31:0] s_axis_prod_tdata;

    logic        m_axis_a_tvalid;
    logic        m_axis_a_tready;
    logic [31:0] m_axis_a_tdata;

    logic        m_axis_b_tvalid;
    logic        m_axis_b_tready;
    logic [31:0] m_axis_b_tdata;

    logic        s_axis_sum_tvalid;
    logic [31:0] s_axis_sum_tdata;

    logic        m_axis_acc_tvalid;
    logic        m_axis_acc_tready;
    logic [31:0] m_axis_acc_tdata;
    logic [5:0]  m_axis_acc_tuser;
    logic        m_axis_acc_tlast;

    // Environment side: product source, adder and downstream consumer.
    modport master (
        output s_axis_prod_tvalid, s_axis_prod_tdata,
        input  s_axis_prod_tready,
        input  m_axis_a_tvalid, m_axis_a_tdata,
        output m_axis_a_tready,
        input  m_axis_b_tvalid, m_axis_b_tdata,
        output m_axis_b_tready,
        output s_axis_sum_tvalid, s_axis_sum_tdata,
        input  m_axis_acc_tvalid, m_axis_acc_tdata, m_axis_acc_tuser, m_axis_acc_tlast,
        output m_axis_acc_tready
    );

    // Accumulator side.
    modport slave (
        input  s_axis_prod_tvalid, s_axis_prod_tdata,
        output s_axis_prod_tready,
        output m_axis_a_tvalid, m_axis_a_tdata,
        input  m_axis_a_tready,
        output m_axis_b_tvalid, m_axis_b_tdata,
        input  m_axis_b_tready,
        input  s_axis_sum_tvalid, s_axis_sum_tdata,
        output m_axis_acc_tvalid, m_axis_acc_tdata, m_axis_acc_tuser, m_axis_acc_tlast,
        input  m_axis_acc_tready
    );
endinterface

// File: rtl/fp_accum8.sv
// Sums groups of N fp32 products through an external streaming adder and emits
// one indexed coefficient per group (index 0..63, tlast on 63).
module fp_accum8 #(
    parameter int N = 8
) (
    input  logic          aclk,
    input  logic          rst,
    fp_accum8_if.slave    bus,
    output logic          err_unexpected_sum
);

    typedef enum logic [1:0] {S_LOAD, S_ISSUE, S_WAIT, S_OUT} state_t;

    localparam logic [4:0] N_L = 5'(N);

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] bhold_q, bhold_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [5:0]  idx_q, idx_d;
    logic        a_done_q, a_done_d;
    logic        b_done_q, b_done_d;
    logic        err_q, err_d;
    logic        prod_ready_q, prod_ready_d;
    logic        a_valid_q, a_valid_d;
    logic        b_valid_q, b_valid_d;
    logic        acc_valid_q, acc_valid_d;

    logic prod_hs, a_hs, b_hs, acc_hs;
    logic [4:0] cnt_inc;

    assign prod_hs = prod_ready_q && bus.s_axis_prod_tvalid;
    assign a_hs    = a_valid_q && bus.m_axis_a_tready;
    assign b_hs    = b_valid_q && bus.m_axis_b_tready;
    assign acc_hs  = acc_valid_q && bus.m_axis_acc_tready;
    assign cnt_inc = cnt_q + 5'd1;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        bhold_d  = bhold_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        a_done_d = a_done_q;
        b_done_d = b_done_q;
        err_d    = err_q;

        case (state_q)
            S_LOAD: begin
                if (prod_hs) begin
                    // The first product of a group seeds the accumulator without an add.
                    if (cnt_q == 5'd0) begin
                        acc_d   = bus.s_axis_prod_tdata;
                        cnt_d   = 5'd1;
                        state_d = (N_L == 5'd1) ? S_OUT : S_LOAD;
                    end else begin
                        bhold_d = bus.s_axis_prod_tdata;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                a_done_d = a_done_q | a_hs;
                b_done_d = b_done_q | b_hs;
                if (a_done_d && b_done_d) begin
                    a_done_d = 1'b0;
                    b_done_d = 1'b0;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.s_axis_sum_tvalid) begin
                    acc_d   = bus.s_axis_sum_tdata;
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == N_L) ? S_OUT : S_LOAD;
                end
            end
            S_OUT: begin
                if (acc_hs) begin
                    cnt_d   = 5'd0;
                    idx_d   = idx_q + 6'd1;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase

        // The adder cannot be stalled, so a result outside WAIT is dropped and flagged.
        if (bus.s_axis_sum_tvalid && (state_q != S_WAIT)) begin
            err_d = 1'b1;
        end

        prod_ready_d = (state_d == S_LOAD);
        a_valid_d    = (state_d == S_ISSUE) && !a_done_d;
        b_valid_d    = (state_d == S_ISSUE) && !b_done_d;
        acc_valid_d  = (state_d == S_OUT);
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            state_q      <= S_LOAD;
            acc_q        <= 32'd0;
            bhold_q      <= 32'd0;
            cnt_q        <= 5'd0;
            idx_q        <= 6'd0;
            a_done_q     <= 1'b0;
            b_done_q     <= 1'b0;
            err_q        <= 1'b0;
            prod_ready_q <= 1'b1;
            a_valid_q    <= 1'b0;
            b_valid_q    <= 1'b0;
            acc_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            bhold_q      <= bhold_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            a_done_q     <= a_done_d;
            b_done_q     <= b_done_d;
            err_q        <= err_d;
            prod_ready_q <= prod_ready_d;
            a_valid_q    <= a_valid_d;
            b_valid_q    <= b_valid_d;
            acc_valid_q  <= acc_valid_d;
        end
    end

    assign bus.s_axis_prod_tready = prod_ready_q;
    assign bus.m_axis_a_tvalid    = a_valid_q;
    assign bus.m_axis_a_tdata     = acc_q;
    assign bus.m_axis_b_tvalid    = b_valid_q;
    assign bus.m_axis_b_tdata     = bhold_q;
    assign bus.m_axis_acc_tvalid  = acc_valid_q;
    assign bus.m_axis_acc_tdata   = acc_q;
    assign bus.m_axis_acc_tuser   = idx_q;
    assign bus.m_axis_acc_tlast   = (idx_q == 6'd63);
    assign err_unexpected_sum     = err_q;

endmodule

// File: tb/tb_fp_accum8.sv
// Bench for fp_accum8: behavioural fp32 adder with latency L, scoreboard of
// expected coefficients, and operand/output stall checks.
module tb_fp_accum8;

    localparam int L = 4;

    logic aclk = 1'b0;
    logic rst  = 1'b1;
    logic err;

    fp_accum8_if bus();

    fp_accum8 #(.N(8)) dut (
        .aclk               (aclk),
        .rst                (rst),
        .bus                (bus),
        .err_unexpected_sum (err)
    );

    always #5 aclk = ~aclk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // fp32 <-> real helpers (normal numbers and zero are all this bench uses)
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] b;
        if (f[30:23] == 8'd0) return 0.0;
        b = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(b);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b;
        logic [24:0] m;
        int e;
        b = $realtobits(r);
        if (b[62:0] == 63'd0) return {b[63], 31'd0};
        e = int'(b[62:52]) - 896;
        m = {2'b01, b[51:29]};
        if (b[28] && ((|b[27:0]) || m[0])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e = e + 1;
        end
        return {b[63], e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    // ---------------- adder model ----------------
    logic        a_rdy_en = 1'b1, b_rdy_en = 1'b1;
    logic        a_have = 1'b0, b_have = 1'b0;
    logic [31:0] a_val = '0, b_val = '0, res = '0;
    int          timer = 0;
    logic        mdl_valid = 1'b0;
    logic [31:0] mdl_data = '0;
    logic        inj = 1'b0;
    int          a_hs_cnt = 0, b_hs_cnt = 0;

    assign bus.m_axis_a_tready   = a_rdy_en && !a_have;
    assign bus.m_axis_b_tready   = b_rdy_en && !b_have;
    assign bus.s_axis_sum_tvalid = mdl_valid | inj;
    assign bus.s_axis_sum_tdata  = inj ? 32'h7FC00000 : mdl_data;

    always @(posedge aclk) begin
        mdl_valid <= 1'b0;
        if (bus.m_axis_a_tvalid && bus.m_axis_a_tready) begin
            a_have   <= 1'b1;
            a_val    <= bus.m_axis_a_tdata;
            a_hs_cnt <= a_hs_cnt + 1;
        end
        if (bus.m_axis_b_tvalid && bus.m_axis_b_tready) begin
            b_have   <= 1'b1;
            b_val    <= bus.m_axis_b_tdata;
            b_hs_cnt <= b_hs_cnt + 1;
        end
        if (a_have && b_have) begin
            a_have <= 1'b0;
            b_have <= 1'b0;
            res    <= fadd(a_val, b_val);
            timer  <= L;
        end else if (timer > 0) begin
            timer <= timer - 1;
            if (timer == 1) begin
                mdl_valid <= 1'b1;
                mdl_data  <= res;
            end
        end
    end

    // ---------------- busy / operand stall monitor ----------------
    logic        mon_en = 1'b1;
    logic        a_pend = 1'b0, b_pend = 1'b0;
    logic [31:0] a_prev = '0, b_prev = '0;

    always @(negedge aclk) begin
        if (rst || !mon_en) begin
            a_pend = 1'b0;
            b_pend = 1'b0;
        end else begin
            if (bus.m_axis_a_tvalid || bus.m_axis_b_tvalid || timer > 0 || mdl_valid
                || bus.m_axis_acc_tvalid)
                check("prod_rdy_busy", 32'(bus.s_axis_prod_tready), 32'd0);
            if (a_pend) begin
                check("a_hold_valid", 32'(bus.m_axis_a_tvalid), 32'd1);
                check("a_hold_data", bus.m_axis_a_tdata, a_prev);
            end
            if (b_pend) begin
                check("b_hold_valid", 32'(bus.m_axis_b_tvalid), 32'd1);
                check("b_hold_data", bus.m_axis_b_tdata, b_prev);
            end
            a_pend = bus.m_axis_a_tvalid && !bus.m_axis_a_tready;
            a_prev = bus.m_axis_a_tdata;
            b_pend = bus.m_axis_b_tvalid && !bus.m_axis_b_tready;
            b_prev = bus.m_axis_b_tdata;
        end
    end

    // ---------------- scoreboard / output collector ----------------
    typedef struct {
        logic [31:0] d;
        logic [5:0]  u;
        logic        l;
    } exp_t;

    exp_t        sb_q[$];
    logic [5:0]  exp_idx = 6'd0;
    int          exp_adds = 0;
    logic        acc_stall = 1'b0;
    logic [31:0] held_d = '0;
    logic [5:0]  held_u = '0;
    logic        held_l = 1'b0;
    logic        tog_en = 1'b0;

    initial begin
        bus.m_axis_acc_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            if (tog_en) bus.m_axis_acc_tready = ~bus.m_axis_acc_tready;
            else        bus.m_axis_acc_tready = 1'b1;
        end
    end

    always @(negedge aclk) begin
        exp_t e;
        if (rst) begin
            acc_stall = 1'b0;
        end else begin
            if (acc_stall) begin
                check("acc_hold_valid", 32'(bus.m_axis_acc_tvalid), 32'd1);
                check("acc_hold_data", bus.m_axis_acc_tdata, held_d);
                check("acc_hold_user", 32'(bus.m_axis_acc_tuser), 32'(held_u));
                check("acc_hold_last", 32'(bus.m_axis_acc_tlast), 32'(held_l));
            end
            if (bus.m_axis_acc_tvalid && bus.m_axis_acc_tready) begin
                $display("out tuser=%0d tdata=%h tlast=%0d", bus.m_axis_acc_tuser,
                         bus.m_axis_acc_tdata, bus.m_axis_acc_tlast);
                check("out_expected", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("out_data", bus.m_axis_acc_tdata, e.d);
                    check("out_user", 32'(bus.m_axis_acc_tuser), 32'(e.u));
                    check("out_last", 32'(bus.m_axis_acc_tlast), 32'(e.l));
                end
                acc_stall = 1'b0;
            end else begin
                acc_stall = bus.m_axis_acc_tvalid;
                held_d    = bus.m_axis_acc_tdata;
                held_u    = bus.m_axis_acc_tuser;
                held_l    = bus.m_axis_acc_tlast;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_prod(input logic [31:0] d);
        int t = 0;
        @(negedge aclk);
        bus.s_axis_prod_tvalid = 1'b1;
        bus.s_axis_prod_tdata  = d;
        while (!bus.s_axis_prod_tready && t < 500) begin
            @(negedge aclk);
            t++;
        end
        check("prod_timeout", 32'(t >= 500), 32'd0);
        @(posedge aclk);
        #1;
        bus.s_axis_prod_tvalid = 1'b0;
        bus.s_axis_prod_tdata  = 32'd0;
    endtask

    task automatic send_group(input logic [31:0] p[8]);
        exp_t e;
        logic [31:0] s;
        s = p[0];
        for (int i = 1; i < 8; i++) s = fadd(s, p[i]);
        e.d = s;
        e.u = exp_idx;
        e.l = (exp_idx == 6'd63);
        sb_q.push_back(e);
        exp_idx  = exp_idx + 6'd1;
        exp_adds = exp_adds + 7;
        for (int i = 0; i < 8; i++) send_prod(p[i]);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb_q.size() != 0 && t < 2000) begin
            @(negedge aclk);
            t++;
        end
        check("drain_timeout", 32'(t >= 2000), 32'd0);
        repeat (2) @(negedge aclk);
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_prod_rdy"}, 32'(bus.s_axis_prod_tready), 32'd1);
        check({pfx, "_a_valid"}, 32'(bus.m_axis_a_tvalid), 32'd0);
        check({pfx, "_b_valid"}, 32'(bus.m_axis_b_tvalid), 32'd0);
        check({pfx, "_acc_valid"}, 32'(bus.m_axis_acc_tvalid), 32'd0);
        check({pfx, "_a_data"}, bus.m_axis_a_tdata, 32'd0);
        check({pfx, "_b_data"}, bus.m_axis_b_tdata, 32'd0);
        check({pfx, "_acc_data"}, bus.m_axis_acc_tdata, 32'd0);
        check({pfx, "_acc_user"}, 32'(bus.m_axis_acc_tuser), 32'd0);
        check({pfx, "_acc_last"}, 32'(bus.m_axis_acc_tlast), 32'd0);
        check({pfx, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic wait_count_change(input int which, input int base);
        int t = 0;
        while (((which == 0) ? a_hs_cnt : b_hs_cnt) == base && t < 500) begin
            @(negedge aclk);
            t++;
        end
        check("hs_wait_timeout", 32'(t >= 500), 32'd0);
    endtask

    initial begin
        logic [31:0] ones[8];
        logic [31:0] mix[8];
        int a0, b0, t;

        for (int i = 0; i < 8; i++) ones[i] = 32'h3F800000;
        mix[0] = 32'h420A3D71;
        mix[1] = 32'h41F5EB85;
        for (int i = 2; i < 8; i++) mix[i] = 32'h00000000;

        bus.s_axis_prod_tvalid = 1'b0;
        bus.s_axis_prod_tdata  = 32'd0;

        rst = 1'b1;
        repeat (3) @(negedge aclk);
        check_reset("rst0");
        rst = 1'b0;

        // 8 x 1.0
        send_group(ones);
        wait_drain();

        // 34.56 + 30.74 + six zeros
        send_group(mix);
        wait_drain();

        // operand back-pressure: A held off on the first add, B on the second
        a0 = a_hs_cnt;
        b0 = b_hs_cnt;
        a_rdy_en = 1'b0;
        fork
            send_group(ones);
            begin
                wait_count_change(1, b0);
                repeat (5) @(negedge aclk);
                a_rdy_en = 1'b1;
                wait_count_change(0, a0);
                b_rdy_en = 1'b0;
                wait_count_change(0, a0 + 1);
                repeat (5) @(negedge aclk);
                b_rdy_en = 1'b1;
            end
        join
        wait_drain();
        check("bp_a_handshakes", 32'(a_hs_cnt - a0), 32'd7);
        check("bp_b_handshakes", 32'(b_hs_cnt - b0), 32'd7);

        // stray adder result while idle in LOAD
        check("err_before", 32'(err), 32'd0);
        @(negedge aclk);
        inj = 1'b1;
        @(negedge aclk);
        inj = 1'b0;
        @(negedge aclk);
        check("err_set", 32'(err), 32'd1);
        send_group(ones);
        wait_drain();
        check("err_sticky", 32'(err), 32'd1);

        // reset while an add is in flight
        send_prod(32'h3F800000);
        send_prod(32'h3F800000);
        exp_adds = exp_adds + 1;
        t = 0;
        while (timer == 0 && t < 100) begin
            @(negedge aclk);
            t++;
        end
        check("wait_state_timeout", 32'(t >= 100), 32'd0);
        mon_en = 1'b0;
        rst = 1'b1;
        repeat (L + 2) @(negedge aclk);
        check_reset("rst1");
        rst = 1'b0;
        exp_idx = 6'd0;
        @(negedge aclk);
        mon_en = 1'b1;
        send_group(ones);
        wait_drain();

        // 64 more groups under output back-pressure: idx 1..63 then wrap to 0
        tog_en = 1'b1;
        for (int g = 0; g < 64; g++) send_group(ones);
        wait_drain();
        tog_en = 1'b0;

        check("total_a_handshakes", 32'(a_hs_cnt), 32'(exp_adds));
        check("total_b_handshakes", 32'(b_hs_cnt), 32'(exp_adds));
        check("err_final", 32'(err), 32'd0);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
